// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched
//   Iterative DES subkey generator. A key is accepted in IDLE, and the block
//   then emits one 48-bit subkey per handshake: K1..K16 when decrypt=0, or
//   K16..K1 when decrypt=1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_valid/key_ready key handshake (key_ready high only in IDLE)
//   key_in[63:0]        DES key, FIPS bit 1 = key_in[63]; parity bits ignored
//   decrypt             direction, sampled together with the key
//   sk_valid/sk_ready   subkey handshake
//   sk_data[47:0]       subkey, FIPS bit 1 = sk_data[47]
//   sk_round[3:0]       index of the current subkey in emission order
//   sk_last             current subkey is the 16th
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk_data,
  output logic [3:0]  sk_round,
  output logic        sk_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS 46-3 tables, 1-based bit numbers, MSB-first.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  // SHIFT[idx] (1-based) is 1 for idx in {1,2,9,16}, else 2.
  function automatic logic shift_is_two(input logic [4:0] idx);
    return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q;
  logic        dir_q;

  logic [55:0] key_pc1;
  logic        enc_two, dec_two;

  always_comb begin
    key_pc1 = pc1(key_in);
    // After emitting subkey r = round+1: encrypt steps forward by SHIFT[r+1],
    // decrypt undoes SHIFT[17-r].
    enc_two = shift_is_two({1'b0, round_q} + 5'd2);
    dec_two = shift_is_two(5'd16 - {1'b0, round_q});
  end

  assign sk_data  = pc2({c_q, d_q});
  assign sk_round = round_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      round_q   <= '0;
      dir_q     <= 1'b0;
      sk_valid  <= 1'b0;
      key_ready <= 1'b1;
      sk_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            // Full rotation sums to 28, so decrypt starts from raw PC1 (=C16/D16);
            // encrypt pre-applies SHIFT[1] to land on C1/D1.
            if (decrypt) begin
              c_q <= key_pc1[55:28];
              d_q <= key_pc1[27:0];
            end else begin
              c_q <= rotl28(key_pc1[55:28], 1'b0);
              d_q <= rotl28(key_pc1[27:0], 1'b0);
            end
            dir_q     <= decrypt;
            round_q   <= '0;
            sk_valid  <= 1'b1;
            key_ready <= 1'b0;
            sk_last   <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (sk_ready) begin
            if (round_q == 4'd15) begin
              round_q   <= '0;
              sk_valid  <= 1'b0;
              key_ready <= 1'b1;
              sk_last   <= 1'b0;
              state     <= IDLE;
            end else begin
              round_q <= round_q + 4'd1;
              sk_last <= (round_q == 4'd14);
              if (dir_q) begin
                c_q <= rotr28(c_q, dec_two);
                d_q <= rotr28(d_q, dec_two);
              end else begin
                c_q <= rotl28(c_q, enc_two);
                d_q <= rotl28(d_q, enc_two);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: randomized keys and backpressure checked
// every cycle against a schedule model that computes Kn directly from the
// cumulative rotation count.
module tb_des_dec_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        sk_valid;
  logic        sk_ready = 1'b0;
  logic [47:0] sk_data;
  logic [3:0]  sk_round;
  logic        sk_last;

  des_dec_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .sk_data   (sk_data),
    .sk_round  (sk_round),
    .sk_last   (sk_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  int hs_count = 0;
  logic [47:0] seen [16];

  localparam logic [63:0] KEY_T = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int unsigned M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int unsigned M_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [27:0] rot_by(input logic [27:0] x, input int n);
    logic [55:0] dbl;
    dbl = {x, x};
    return dbl[55 - n -: 28];
  endfunction

  // Kn (n = 1..16) straight from FIPS: C/D rotated by the sum of SHIFT[1..n].
  function automatic logic [47:0] model_sk(input logic [63:0] key, input int n);
    logic [55:0] cd0, cdn;
    logic [47:0] r;
    int total;
    cd0 = '0;
    for (int i = 0; i < 56; i++) cd0[55 - i] = key[64 - M_PC1[i]];
    total = 0;
    for (int i = 0; i < n; i++) total += M_SHIFT[i];
    total = total % 28;
    cdn = {rot_by(cd0[55:28], total), rot_by(cd0[27:0], total)};
    r = '0;
    for (int i = 0; i < 48; i++) r[47 - i] = cdn[56 - M_PC2[i]];
    return r;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic        m_active = 1'b0;
  logic [63:0] m_key = '0;
  logic        m_dec = 1'b0;
  int          m_idx = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      chk("rst_sk_valid", sk_valid, 0);
      chk("rst_key_ready", key_ready, 1);
      chk("rst_sk_round", sk_round, 0);
      chk("rst_sk_last", sk_last, 0);
      chk("rst_sk_data", sk_data, 0);
    end else begin
      chk("sk_valid", sk_valid, m_active);
      chk("key_ready", key_ready, !m_active);
      if (m_active) begin
        chk("sk_data", sk_data, model_sk(m_key, m_dec ? 16 - m_idx : m_idx + 1));
        chk("sk_round", sk_round, m_idx);
        chk("sk_last", sk_last, m_idx == 15);
        if (sk_ready) begin
          seen[m_idx] = sk_data;
          hs_count++;
          m_idx++;
          if (m_idx == 16) m_active = 1'b0;
        end
      end else if (key_valid) begin
        m_active = 1'b1;
        m_key = key_in;
        m_dec = decrypt;
        m_idx = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sk_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!key_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_key_ready", key_ready, 1);
  endtask

  task automatic send_key(input logic [63:0] k, input logic dec);
    wait_ready();
    key_valid = 1'b1;
    key_in = k;
    decrypt = dec;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = $urandom_range(0, 1);
  endtask

  task automatic run_key(input logic [63:0] k, input logic dec);
    send_key(k, dec);
    wait_ready();
  endtask

  initial begin
    int h0, n;
    logic [63:0] k;
    logic dec;

    // Model pinned to published FIPS vectors.
    chk("model_K1", model_sk(KEY_T, 1), 48'h1B02EFFC7072);
    chk("model_K2", model_sk(KEY_T, 2), 48'h79AED9DBC9E5);
    chk("model_K15", model_sk(KEY_T, 15), 48'hBF918D3D3F0A);
    chk("model_K16", model_sk(KEY_T, 16), 48'hCB3D8B0E17F5);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Forward schedule.
    ready_pct = 100;
    run_key(KEY_T, 1'b0);
    chk("enc_first", seen[0], 48'h1B02EFFC7072);
    chk("enc_second", seen[1], 48'h79AED9DBC9E5);
    chk("enc_last", seen[15], 48'hCB3D8B0E17F5);

    // Reverse schedule.
    run_key(KEY_T, 1'b1);
    chk("dec_first", seen[0], 48'hCB3D8B0E17F5);
    chk("dec_second", seen[1], 48'hBF918D3D3F0A);
    chk("dec_last", seen[15], 48'h1B02EFFC7072);

    // Backpressure, 30% ready.
    ready_pct = 30;
    h0 = hs_count;
    run_key(KEY_T, 1'b1);
    chk("bp_handshakes", hs_count - h0, 16);
    for (int i = 0; i < 16; i++) chk("bp_seq", seen[i], model_sk(KEY_T, 16 - i));

    // key_valid held through EMIT with a different key.
    ready_pct = 100;
    wait_ready();
    key_valid = 1'b1;
    key_in = 64'h0E329232EA6D0D73;
    decrypt = 1'b0;
    @(posedge clk);
    #1;
    key_in = 64'hA1B2C3D4E5F60718;
    decrypt = 1'b1;
    n = 0;
    while (!key_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_key_ready_back", key_ready, 1);
    chk("held_first_run_seq", seen[3], model_sk(64'h0E329232EA6D0D73, 4));
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    chk("held_second_valid", sk_valid, 1);
    chk("held_second_round", sk_round, 0);
    chk("held_second_data", sk_data, model_sk(64'hA1B2C3D4E5F60718, 16));
    wait_ready();

    // Reset mid-stream at round 7.
    send_key(64'h0123456789ABCDEF, 1'b0);
    n = 0;
    while (sk_round != 4'd7 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reached_r7", sk_round, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_sk_valid", sk_valid, 0);
    chk("abort_key_ready", key_ready, 1);
    chk("abort_sk_round", sk_round, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_key(64'hFEDCBA9876543210, 1'b1);
    chk("restart_first", seen[0], model_sk(64'hFEDCBA9876543210, 16));

    // Random keys, both directions, parity bits flipped on the second pass.
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom};
      dec = $urandom_range(0, 1);
      ready_pct = (i % 2 == 0) ? 100 : 70;
      run_key(k, dec);
      run_key(k ^ PAR_MASK, dec);
      chk("parity_inv_last", seen[15], model_sk(k, dec ? 1 : 16));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
